// File: rtl/tour_cmd_seq.sv
// Tour command sequencer: turns each solved knight move into a vertical and a horizontal
// move command for cmd_proc, and passes UART commands through when no tour is running.
module tour_cmd_seq #(
    parameter int          NUM_MOVES = 24,
    parameter int          IDX_W     = 5,
    parameter logic [7:0]  RESP_DONE = 8'hA5,
    parameter logic [7:0]  RESP_BUSY = 8'h5A
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_tour,
    input  logic             abort,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    output logic [7:0]       resp,
    output logic             tour_active,
    output logic             move_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        VERT  = 3'd2,
        HOLDV = 3'd3,
        HORZ  = 3'd4,
        HOLDH = 3'd5
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    // Move encoding must be exactly one-hot; anything else means solver data is corrupt.
    function automatic logic is_one_hot(input logic [7:0] m);
        return (m != 8'h00) && ((m & (m - 8'h01)) == 8'h00);
    endfunction

    // Returns {vertical_cmd, horizontal_cmd}. North=00, South=7F, East=BF, West=3F.
    function automatic logic [31:0] leg_cmds(input logic [7:0] m);
        logic [31:0] c;
        case (m)
            8'h01:   c = {16'h2002, 16'h3BF1};   // (+1,+2)
            8'h02:   c = {16'h2002, 16'h33F1};   // (-1,+2)
            8'h04:   c = {16'h2001, 16'h33F2};   // (-2,+1)
            8'h08:   c = {16'h27F1, 16'h33F2};   // (-2,-1)
            8'h10:   c = {16'h27F2, 16'h33F1};   // (-1,-2)
            8'h20:   c = {16'h27F2, 16'h3BF1};   // (+1,-2)
            8'h40:   c = {16'h27F1, 16'h3BF2};   // (+2,-1)
            8'h80:   c = {16'h2001, 16'h3BF2};   // (+2,+1)
            default: c = 32'h0000_0000;
        endcase
        return c;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [IDX_W-1:0] mv_indx_r, mv_indx_nxt_s;
    logic [7:0]       move_q_r, move_q_nxt_s;
    logic             move_err_r, move_err_nxt_s;
    logic [31:0]      legs_s;

    assign legs_s   = leg_cmds(move_q_r);
    assign mv_indx  = mv_indx_r;
    assign move_err = move_err_r;

    // State and tour bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            mv_indx_r  <= '0;
            move_q_r   <= 8'h00;
            move_err_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            mv_indx_r  <= mv_indx_nxt_s;
            move_q_r   <= move_q_nxt_s;
            move_err_r <= move_err_nxt_s;
        end
    end

    // Next-state logic; abort takes priority over any handshake seen in the same cycle.
    always_comb begin
        state_nxt_s    = state_r;
        mv_indx_nxt_s  = mv_indx_r;
        move_q_nxt_s   = move_q_r;
        move_err_nxt_s = move_err_r;
        if (abort && (state_r != IDLE)) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_tour) begin
                        state_nxt_s    = LOAD;
                        mv_indx_nxt_s  = '0;
                        move_err_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                LOAD: begin
                    move_q_nxt_s = move;
                    if (is_one_hot(move)) begin
                        state_nxt_s = VERT;
                    end else begin
                        state_nxt_s    = IDLE;
                        move_err_nxt_s = 1'b1;
                    end
                end
                VERT: begin
                    if (clr_cmd_rdy) begin
                        state_nxt_s = HOLDV;
                    end else begin
                        state_nxt_s = VERT;
                    end
                end
                HOLDV: begin
                    if (send_resp) begin
                        state_nxt_s = HORZ;
                    end else begin
                        state_nxt_s = HOLDV;
                    end
                end
                HORZ: begin
                    if (clr_cmd_rdy) begin
                        state_nxt_s = HOLDH;
                    end else begin
                        state_nxt_s = HORZ;
                    end
                end
                HOLDH: begin
                    if (send_resp && (mv_indx_r == LAST_IDX)) begin
                        state_nxt_s = IDLE;
                    end else if (send_resp) begin
                        state_nxt_s   = LOAD;
                        mv_indx_nxt_s = mv_indx_r + IDX_W'(1);
                    end else begin
                        state_nxt_s = HOLDH;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Command mux and response byte decoded from the current state.
    always_comb begin
        cmd         = 16'h0000;
        cmd_rdy     = 1'b0;
        resp        = RESP_BUSY;
        tour_active = 1'b1;
        case (state_r)
            IDLE: begin
                cmd         = cmd_UART;
                cmd_rdy     = cmd_rdy_UART;
                resp        = RESP_DONE;
                tour_active = 1'b0;
            end
            LOAD: begin
                cmd = 16'h0000;
            end
            VERT: begin
                cmd     = legs_s[31:16];
                cmd_rdy = 1'b1;
            end
            HOLDV: begin
                cmd = legs_s[31:16];
            end
            HORZ: begin
                cmd     = legs_s[15:0];
                cmd_rdy = 1'b1;
            end
            HOLDH: begin
                cmd = legs_s[15:0];
                if (mv_indx_r == LAST_IDX) begin
                    resp = RESP_DONE;
                end else begin
                    resp = RESP_BUSY;
                end
            end
            default: begin
                resp        = RESP_DONE;
                tour_active = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Self-checking bench for tour_cmd_seq: a 24-move instance and a 2-move instance, with a
// scoreboard of expected leg commands/responses derived from the knight (dx,dy) table.
module tb_tour_cmd_seq;

    logic        clk = 1'b0;
    logic        rst, start1, start2, abort, clr_cmd_rdy, send_resp, cmd_rdy_UART;
    logic [15:0] cmd_UART;
    logic [7:0]  move1, move2;
    logic [4:0]  mv1, mv2;
    logic [15:0] cmd1, cmd2;
    logic        rdy1, rdy2, act1, act2, err1, err2;
    logic [7:0]  resp1, resp2;
    logic [7:0]  tour1 [32];
    logic [7:0]  tour2 [32];

    logic        sel;
    logic [15:0] obs_cmd;
    logic        obs_rdy, obs_act;
    logic [7:0]  obs_resp;
    logic [4:0]  obs_idx;

    typedef struct {
        logic [15:0] cmd;
        logic [7:0]  resp;
        logic [4:0]  idx;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   a5_cnt = 0;
    int   legs   = 0;

    always #5 clk = ~clk;

    assign move1    = tour1[mv1];
    assign move2    = tour2[mv2];
    assign obs_cmd  = sel ? cmd2  : cmd1;
    assign obs_rdy  = sel ? rdy2  : rdy1;
    assign obs_act  = sel ? act2  : act1;
    assign obs_resp = sel ? resp2 : resp1;
    assign obs_idx  = sel ? mv2   : mv1;

    tour_cmd_seq #(.NUM_MOVES(24), .IDX_W(5)) dut (
        .clk(clk), .rst(rst), .start_tour(start1), .abort(abort), .move(move1),
        .mv_indx(mv1), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .cmd(cmd1), .cmd_rdy(rdy1),
        .resp(resp1), .tour_active(act1), .move_err(err1)
    );

    tour_cmd_seq #(.NUM_MOVES(2), .IDX_W(5)) dut2 (
        .clk(clk), .rst(rst), .start_tour(start2), .abort(abort), .move(move2),
        .mv_indx(mv2), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .cmd(cmd2), .cmd_rdy(rdy2),
        .resp(resp2), .tour_active(act2), .move_err(err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_legs(input logic [7:0] m, output logic [15:0] v,
                                       output logic [15:0] h);
        int dx_t [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
        int dy_t [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
        int k = 0;
        int dx, dy;
        for (int i = 0; i < 8; i++) if (m[i]) k = i;
        dx = dx_t[k];
        dy = dy_t[k];
        v = {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
        h = {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
    endfunction

    task automatic push_tour(input bit which, input int n);
        exp_t e;
        logic [15:0] v, h;
        logic [7:0] m;
        for (int i = 0; i < n; i++) begin
            m = which ? tour2[i] : tour1[i];
            model_legs(m, v, h);
            e.idx  = i[4:0];
            e.cmd  = v;
            e.resp = 8'h5A;
            sb.push_back(e);
            e.cmd  = h;
            e.resp = (i == n - 1) ? 8'hA5 : 8'h5A;
            sb.push_back(e);
        end
    endtask

    task automatic serve_leg(input bit noise);
        exp_t e;
        int n = 0;
        while (obs_rdy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (obs_rdy !== 1'b1) begin
            errors++;
            $display("FAIL leg_wait: cmd_rdy=%b required 1 within 20 cycles", obs_rdy);
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: unexpected command %h", obs_cmd);
            return;
        end
        e = sb.pop_front();
        legs++;
        checks++;
        if (obs_cmd !== e.cmd) begin
            errors++;
            $display("FAIL leg_cmd: cmd=%h required %h", obs_cmd, e.cmd);
        end
        checks++;
        if (obs_idx !== e.idx) begin
            errors++;
            $display("FAIL leg_idx: mv_indx=%0d required %0d", obs_idx, e.idx);
        end
        checks++;
        if (obs_resp !== 8'h5A) begin
            errors++;
            $display("FAIL leg_resp_busy: resp=%h required 5a", obs_resp);
        end
        if (noise) begin
            repeat ($urandom_range(0, 3)) begin
                send_resp = ($urandom_range(0, 1) == 1);
                tick();
                send_resp = 1'b0;
            end
        end
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        checks++;
        if (obs_rdy !== 1'b0) begin
            errors++;
            $display("FAIL hold_rdy: cmd_rdy=%b required 0", obs_rdy);
        end
        checks++;
        if (obs_resp !== e.resp) begin
            errors++;
            $display("FAIL hold_resp: resp=%h required %h", obs_resp, e.resp);
        end
        if (obs_resp === 8'hA5) a5_cnt++;
        if (noise) repeat ($urandom_range(0, 3)) tick();
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
    endtask

    task automatic start_pulse(input bit which);
        if (which) start2 = 1'b1; else start1 = 1'b1;
        tick();
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({act1, act2, err1, err2} !== 4'b0000 || mv1 !== 5'd0 || mv2 !== 5'd0) begin
            errors++;
            $display("FAIL reset_state: act=%b%b err=%b%b mv=%0d/%0d required zeros",
                     act1, act2, err1, err2, mv1, mv2);
        end
        checks++;
        if (resp1 !== 8'hA5 || resp2 !== 8'hA5) begin
            errors++;
            $display("FAIL reset_resp: resp=%h/%h required a5", resp1, resp2);
        end
    endtask

    task automatic test_passthrough();
        sel = 1'b0;
        cmd_UART = 16'h2004;
        cmd_rdy_UART = 1'b1;
        #1;
        checks++;
        if (obs_cmd !== 16'h2004 || obs_rdy !== 1'b1 || obs_resp !== 8'hA5) begin
            errors++;
            $display("FAIL passthru: cmd=%h rdy=%b resp=%h required 2004 1 a5",
                     obs_cmd, obs_rdy, obs_resp);
        end
        cmd_rdy_UART = 1'b0;
        #1;
        checks++;
        if (obs_rdy !== 1'b0) begin
            errors++;
            $display("FAIL passthru_idle: cmd_rdy=%b required 0", obs_rdy);
        end
    endtask

    task automatic test_two_move_tour();
        sel = 1'b1;
        tour2[0] = 8'h01;
        tour2[1] = 8'h40;
        sb.delete();
        push_tour(1'b1, 2);
        cmd_UART = 16'hFFFF;
        cmd_rdy_UART = 1'b1;
        start_pulse(1'b1);
        checks++;
        if (obs_rdy !== 1'b0 || obs_act !== 1'b1 || obs_resp !== 8'h5A) begin
            errors++;
            $display("FAIL load_state: rdy=%b act=%b resp=%h required 0 1 5a",
                     obs_rdy, obs_act, obs_resp);
        end
        tick();
        checks++;
        if (obs_rdy !== 1'b1) begin
            errors++;
            $display("FAIL first_rdy_latency: cmd_rdy=%b required 1", obs_rdy);
        end
        for (int i = 0; i < 4; i++) serve_leg(1'b0);
        cmd_rdy_UART = 1'b0;
        #1;
        checks++;
        if (obs_act !== 1'b0 || obs_resp !== 8'hA5 || sb.size() != 0) begin
            errors++;
            $display("FAIL two_move_end: act=%b resp=%h left=%0d required 0 a5 0",
                     obs_act, obs_resp, sb.size());
        end
    endtask

    task automatic test_illegal_move();
        sel = 1'b0;
        tour1[0] = 8'h03;
        start_pulse(1'b0);
        checks++;
        if (rdy1 !== 1'b0) begin
            errors++;
            $display("FAIL illegal_rdy: cmd_rdy=%b required 0", rdy1);
        end
        tick();
        checks++;
        if (err1 !== 1'b1 || act1 !== 1'b0 || rdy1 !== 1'b0) begin
            errors++;
            $display("FAIL illegal_move: err=%b act=%b rdy=%b required 1 0 0", err1, act1, rdy1);
        end
        tour1[0] = 8'h01;
        start_pulse(1'b0);
        checks++;
        if (err1 !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: move_err=%b required 0", err1);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (act1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_load: tour_active=%b required 0", act1);
        end
    endtask

    task automatic test_abort();
        sel = 1'b0;
        tour1[0] = 8'h01;
        tour1[1] = 8'h40;
        sb.delete();
        push_tour(1'b0, 2);
        start_pulse(1'b0);
        tick();
        for (int i = 0; i < 3; i++) serve_leg(1'b0);
        start_pulse(1'b0);
        checks++;
        if (mv1 !== 5'd1 || rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored: mv_indx=%0d rdy=%b required 1 1", mv1, rdy1);
        end
        abort = 1'b1;
        clr_cmd_rdy = 1'b1;
        tick();
        abort = 1'b0;
        clr_cmd_rdy = 1'b0;
        checks++;
        if (rdy1 !== 1'b0 || act1 !== 1'b0 || mv1 !== 5'd1 || resp1 !== 8'hA5) begin
            errors++;
            $display("FAIL abort_horz: rdy=%b act=%b mv=%0d resp=%h required 0 0 1 a5",
                     rdy1, act1, mv1, resp1);
        end
        sb.delete();
    endtask

    task automatic test_full_tour();
        sel = 1'b0;
        for (int i = 0; i < 24; i++) tour1[i] = 8'h01 << $urandom_range(0, 7);
        sb.delete();
        push_tour(1'b0, 24);
        a5_cnt = 0;
        legs = 0;
        start_pulse(1'b0);
        tick();
        for (int i = 0; i < 48; i++) serve_leg(1'b1);
        #1;
        checks++;
        if (act1 !== 1'b0 || a5_cnt != 1 || legs != 48 || sb.size() != 0) begin
            errors++;
            $display("FAIL full_tour: act=%b a5=%0d legs=%0d left=%0d required 0 1 48 0",
                     act1, a5_cnt, legs, sb.size());
        end
    endtask

    task automatic test_reset_mid_tour();
        sel = 1'b0;
        sb.delete();
        push_tour(1'b0, 24);
        start_pulse(1'b0);
        tick();
        serve_leg(1'b0);
        serve_leg(1'b0);
        tick();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        checks++;
        if (act1 !== 1'b1 || mv1 !== 5'd1) begin
            errors++;
            $display("FAIL holdv_reached: act=%b mv=%0d required 1 1", act1, mv1);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (act1 !== 1'b0 || mv1 !== 5'd0 || resp1 !== 8'hA5 || rdy1 !== 1'b0 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: act=%b mv=%0d resp=%h rdy=%b err=%b required 0 0 a5 0 0",
                     act1, mv1, resp1, rdy1, err1);
        end
        tick();
        rst = 1'b0;
        sb.delete();
        push_tour(1'b0, 24);
        start_pulse(1'b0);
        tick();
        serve_leg(1'b0);
        sb.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        {start1, start2, abort, clr_cmd_rdy, send_resp, cmd_rdy_UART} = 6'b000000;
        cmd_UART = 16'h0000;
        sel = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tour1[i] = 8'h01;
            tour2[i] = 8'h01;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_passthrough();
        test_two_move_tour();
        test_illegal_move();
        test_abort();
        test_full_tour();
        test_reset_mid_tour();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
